// File: rtl/inner_9_sched.sv
// ---------------------------------------------------------------------------
// inner_9_sched
// Sequencer for one shared 3x3 dot-product unit. For every output pixel it
// streams num_ch window/kernel operand pairs into the dot unit, tags each
// load so that only real operands are accumulated once they emerge from the
// unit's load-gated pipeline, adds the per-pixel bias, saturates, and hands
// the finished pixel to the output buffer over a valid/ready port.
//
// Ports
//   clk, rst              clock (posedge) and synchronous active-high reset
//   start                 job start pulse, honoured only in IDLE
//   num_ch, num_out       channels per pixel / pixels per job, latched on start
//   bias                  signed accumulator seed, sampled at each pixel start
//   busy, done            job in progress / one-cycle completion pulse
//   src_valid/src_ready   operand pair handshake, src_d1 window, src_d2 kernel
//   dot_load, dot_d1/d2   load enable and operands for the dot unit
//   dot_q                 signed dot unit result (PIPE_LAT loads behind)
//   out_valid/out_ready   pixel handshake, out_data saturated pixel sum
// ---------------------------------------------------------------------------
module inner_9_sched #(
    parameter int DATA_LEN = 16,
    parameter int CH_W     = 8,
    parameter int OUT_W    = 12,
    parameter int PIPE_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CH_W-1:0]       num_ch,
    input  logic [OUT_W-1:0]      num_out,
    input  logic [DATA_LEN-1:0]   bias,
    output logic                  busy,
    output logic                  done,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [9*DATA_LEN-1:0] src_d1,
    input  logic [9*DATA_LEN-1:0] src_d2,
    output logic                  dot_load,
    output logic [9*DATA_LEN-1:0] dot_d1,
    output logic [9*DATA_LEN-1:0] dot_d2,
    input  logic [DATA_LEN-1:0]   dot_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam int FL_W = $clog2(PIPE_LAT) + 1;
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(PIPE_LAT - 2);

    state_t                state, state_nx;
    logic [CH_W-1:0]       ch_num;
    logic [CH_W-1:0]       ch_left;
    logic [OUT_W-1:0]      pix_left;
    logic [FL_W-1:0]       flush_cnt;
    logic [2:0]            vtag;
    logic                  ld_r;
    logic [DATA_LEN-1:0]   acc;
    logic [DATA_LEN:0]     sum_ext;
    logic [DATA_LEN-1:0]   acc_sat;

    logic accept;
    logic start_ok;
    logic start_empty;
    logic out_fire;
    logic last_pix;

    assign accept      = (state == S_FEED) && src_valid;
    assign start_ok    = (state == S_IDLE) && start && (num_ch != '0) && (num_out != '0);
    assign start_empty = (state == S_IDLE) && start && ((num_ch == '0) || (num_out == '0));
    assign out_fire    = (state == S_OUT) && out_ready;
    assign last_pix    = (pix_left == OUT_W'(1));

    assign busy     = (state != S_IDLE);
    assign out_data = acc;

    // Sign-extended sum one bit wider than the accumulator; the top two bits
    // disagreeing means the true result left the representable range, and the
    // top bit then says which rail to clamp to.
    assign sum_ext = {acc[DATA_LEN-1], acc} + {dot_q[DATA_LEN-1], dot_q};
    always_comb begin
        acc_sat = sum_ext[DATA_LEN-1:0];
        if (sum_ext[DATA_LEN] != sum_ext[DATA_LEN-1]) begin
            acc_sat = sum_ext[DATA_LEN] ? {1'b1, {(DATA_LEN-1){1'b0}}}
                                        : {1'b0, {(DATA_LEN-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and Moore/Mealy outputs. Operands pass straight through in
    // FEED so the dot unit captures them on the accepting edge; FLUSH pushes
    // zeros to shove the last real operands out of the unit's pipeline.
    always_comb begin
        state_nx  = state;
        src_ready = 1'b0;
        dot_load  = 1'b0;
        dot_d1    = '0;
        dot_d2    = '0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nx = S_FEED;
                end
            end
            S_FEED: begin
                src_ready = 1'b1;
                dot_load  = src_valid;
                dot_d1    = src_d1;
                dot_d2    = src_d2;
                if (src_valid && (ch_left == CH_W'(1))) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                dot_load = 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = last_pix ? S_IDLE : S_FEED;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Counters, tag pipeline and accumulator. vtag mirrors the dot unit's
    // load-gated stages: bit 2 marks whether the word now on dot_q came from a
    // real operand, and ld_r marks that dot_q changed on the previous edge, so
    // each real result is added exactly once and stalls cause no re-adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            ch_num    <= '0;
            ch_left   <= '0;
            pix_left  <= '0;
            flush_cnt <= '0;
            vtag      <= '0;
            ld_r      <= 1'b0;
            acc       <= '0;
        end else begin
            done <= start_empty || (out_fire && last_pix);
            ld_r <= dot_load;
            if (dot_load) begin
                vtag <= {vtag[1:0], accept};
            end
            if (start_ok) begin
                ch_num   <= num_ch;
                ch_left  <= num_ch;
                pix_left <= num_out;
                acc      <= bias;
            end
            if (accept) begin
                ch_left <= ch_left - CH_W'(1);
            end
            if (state == S_FLUSH) begin
                flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + FL_W'(1);
            end
            if (ld_r && vtag[2]) begin
                acc <= acc_sat;
            end
            if (out_fire) begin
                pix_left <= pix_left - OUT_W'(1);
                if (!last_pix) begin
                    acc     <= bias;
                    ch_left <= ch_num;
                end
            end
        end
    end

endmodule
